mult_sequencer: RTL and testbench

- Iterative shift-add multiply unit with its own controller. It replaces the combinational multiplier on the MUL/MULU path of the single-cycle datapath.
- Control asserts start when the decoded instruction has mul=1. The block raises stall to freeze the PC, instruction fetch and the register-file write.
- It computes the low WIDTH bits of X*Y over 1..WIDTH cycles, then presents Z for exactly one non-stalled cycle so the instruction retires normally.

---
 rtl/mult_sequencer.sv | 115 +++++++++++
 tb/tb_mult_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier with its own controller; stalls the datapath
// while running and presents the low WIDTH product bits for one DONE cycle.
module mult_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 6,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             stall,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] Z,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State register; reset discards any in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, datapath and stall generation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    iter_d  = iter_q;
    stall   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          a_d     = X;
          b_d     = Y;
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (b_q[0]) begin
          p_d = p_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Early exit once no multiplier bits remain to be consumed.
        if ((cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_TERM && (b_d == '0))) begin
          state_d = S_DONE;
          z_d     = p_d;
          iter_d  = cnt_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN);
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign Z          = z_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: one early-terminating and one
// full-length instance, checked against hand-computed products and cycle counts.
module tb_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start_nt;
  logic [31:0] X;
  logic [31:0] Y;

  logic        stall, done, busy;
  logic [31:0] z;
  logic [5:0]  iter;
  logic        stall_nt, done_nt, busy_nt;
  logic [31:0] z_nt;
  logic [5:0]  iter_nt;

  int n_checks;
  int n_fail;

  mult_sequencer #(.WIDTH(32), .CNT_W(6), .EARLY_TERM(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y),
    .stall(stall), .done(done), .busy(busy), .Z(z), .iter_count(iter)
  );

  mult_sequencer #(.WIDTH(32), .CNT_W(6), .EARLY_TERM(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .start(start_nt), .X(X), .Y(Y),
    .stall(stall_nt), .done(done_nt), .busy(busy_nt), .Z(z_nt), .iter_count(iter_nt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_nt = 1'b0; X = '0; Y = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({stall, done, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: stall/done/busy=%b expected 000", {stall, done, busy});
    end
    n_checks++;
    if (z !== 32'd0 || iter !== 6'd0) begin
      n_fail++; $display("FAIL reset_regs: Z=%h iter=%0d expected 0/0", z, iter);
    end
    n_checks++;
    if ({stall_nt, done_nt, busy_nt} !== 3'b000 || z_nt !== 32'd0 || iter_nt !== 6'd0) begin
      n_fail++; $display("FAIL reset_nt: ctrl=%b Z=%h iter=%0d expected 000/0/0",
                         {stall_nt, done_nt, busy_nt}, z_nt, iter_nt);
    end
    reset = 1'b0;
  endtask

  // Runs one multiply starting in the next (IDLE) cycle; returns in the DONE cycle.
  task automatic run_mul(input bit nt, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ez, input int en, input bit hold, input string nm);
    int          cyc;
    bit          got;
    bit          run_bad;
    logic [31:0] z_prev;
    @(posedge clk); #1;
    z_prev = nt ? z_nt : z;
    X = x; Y = y;
    if (nt) start_nt = 1'b1; else start = 1'b1;
    #1;
    n_checks++;
    if ((nt ? stall_nt : stall) !== 1'b1) begin
      n_fail++; $display("FAIL %s_accept_stall: stall=%b expected 1", nm, nt ? stall_nt : stall);
    end
    cyc = 0; got = 1'b0; run_bad = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (nt ? done_nt : done) got = 1'b1;
      else begin
        if ((nt ? busy_nt : busy) !== 1'b1 || (nt ? stall_nt : stall) !== 1'b1 ||
            (nt ? z_nt : z) !== z_prev) run_bad = 1'b1;
        cyc++;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL %s_timeout: done not seen, got 0 expected 1", nm);
    end
    n_checks++;
    if (run_bad) begin
      n_fail++; $display("FAIL %s_run_ctrl: busy/stall/Z-hold bad during RUN, got 1 expected 0", nm);
    end
    n_checks++;
    if (cyc != en) begin
      n_fail++; $display("FAIL %s_cycles: got %0d RUN cycles expected %0d", nm, cyc, en);
    end
    n_checks++;
    if ((nt ? z_nt : z) !== ez) begin
      n_fail++; $display("FAIL %s_z: got %h expected %h", nm, nt ? z_nt : z, ez);
    end
    n_checks++;
    if ((nt ? iter_nt : iter) !== 6'(en)) begin
      n_fail++; $display("FAIL %s_iter: got %0d expected %0d", nm, nt ? iter_nt : iter, en);
    end
    n_checks++;
    if ((nt ? stall_nt : stall) !== 1'b0 || (nt ? busy_nt : busy) !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_ctrl: stall=%b busy=%b expected 0/0", nm,
                         nt ? stall_nt : stall, nt ? busy_nt : busy);
    end
    if (!hold) begin
      if (nt) start_nt = 1'b0; else start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ((nt ? done_nt : done) !== 1'b0 || (nt ? stall_nt : stall) !== 1'b0) begin
        n_fail++; $display("FAIL %s_after: done=%b stall=%b expected 0/0", nm,
                           nt ? done_nt : done, nt ? stall_nt : stall);
      end
    end
  endtask

  task automatic test_basic();
    run_mul(1'b0, 32'd3, 32'd5, 32'd15, 3, 1'b0, "mul3x5");
  endtask

  task automatic test_zero();
    run_mul(1'b0, 32'h1234_5678, 32'd0, 32'd0, 1, 1'b0, "zero_et");
    run_mul(1'b1, 32'h1234_5678, 32'd0, 32'd0, 32, 1'b0, "zero_full");
  endtask

  task automatic test_wide();
    run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b0, "allones");
    run_mul(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 1'b0, "signed");
    run_mul(1'b1, 32'd3, 32'd5, 32'd15, 32, 1'b0, "full3x5");
  endtask

  task automatic test_midrun_ignore();
    int cyc;
    bit got;
    @(posedge clk); #1;
    X = 32'd2; Y = 32'd9; start = 1'b1;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
      else begin
        cyc++;
        if (cyc == 2) begin X = '0; Y = '0; start = 1'b0; end
        if (cyc == 3) start = 1'b1;
      end
    end
    start = 1'b0;
    n_checks++;
    if (!got || cyc != 4) begin
      n_fail++; $display("FAIL midrun_cycles: done=%b cycles=%0d expected 1/4", got, cyc);
    end
    n_checks++;
    if (z !== 32'd18) begin
      n_fail++; $display("FAIL midrun_z: got %0d expected 18", z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    @(posedge clk); #1;
    X = 32'd5; Y = 32'h8000_0000; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({stall, busy, done} !== 3'b000 || z !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_state: stall/busy/done=%b Z=%h expected 000/0",
                         {stall, busy, done}, z);
    end
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy || z !== 32'd0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL rst_mid_publish: result published after reset, got 1 expected 0");
    end
    run_mul(1'b0, 32'd6, 32'd7, 32'd42, 3, 1'b0, "post_rst");
  endtask

  task automatic test_back_to_back();
    run_mul(1'b0, 32'd4, 32'd4, 32'd16, 3, 1'b1, "b2b_first");
    run_mul(1'b0, 32'd10, 32'd10, 32'd100, 4, 1'b0, "b2b_second");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_zero();
    test_wide();
    test_midrun_ignore();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
